// File: rtl/blink.sv
// Board bring-up LED blinker: divides clk down to a visible square wave on one pin.
// Latency: led changes on the same edge as the internal phase (plain build), or one
//   edge later when the BLINK_PWM_DIM_EN dimming option is compiled in.
// Backpressure: none; free-running leaf with no handshake.
//
// Ports:
//   clk  in   1  system clock, all logic on the rising edge
//   rst  in   1  synchronous reset, active-high
//   led  out  1  registered LED drive (inverted when LED_ACTIVE_LOW=1)
//
// Optional feature macro: BLINK_PWM_DIM_EN
//   When defined, an 8-bit free-running PWM counter gates the lit phase so the LED
//   is on DIM_DUTY out of every 256 cycles while lit.
//
// Every register carries a declaration initialiser equal to its reset value, so the
// block blinks correctly from power-up even if rst is tied low. An X/Z rst falls
// through the if (rst) test into the running path.

module blink #(
  parameter int CLK_HZ         = 100_000_000,
  parameter int BLINK_HZ       = 100,
  parameter bit LED_ACTIVE_LOW = 1'b0,
  parameter int DIM_DUTY       = 64
) (
  input  logic clk,
  input  logic rst,
  output logic led
);

  // Cycles per half period of the blink.
  localparam int HALF = (BLINK_HZ > 0) ? (CLK_HZ / (2 * BLINK_HZ)) : 0;

  // Counter width is max(1, clog2(HALF)); HALF==1 still gets a 1-bit counter.
  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'((HALF > 0) ? (HALF - 1) : 0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Off level of the physical pin.
  localparam logic OFF_LVL = LED_ACTIVE_LOW;

  generate
    if (HALF < 1) begin : g_half_chk
      $error("blink: CLK_HZ/(2*BLINK_HZ) must be at least 1");
    end
  endgenerate

  // The blink phase is a two-state machine: off half, lit half.
  typedef enum logic {
    PH_OFF = 1'b0,
    PH_ON  = 1'b1
  } phase_t;

  logic [CW-1:0] cnt      = '0;
  logic [CW-1:0] cnt_nxt;
  phase_t        phase    = PH_OFF;
  phase_t        phase_nxt;
  logic          led_q    = OFF_LVL;
  logic          led_nxt;
  logic          wrap;

  // ------------------------------------------------------------------
  // Divider and phase next-state
  // ------------------------------------------------------------------
  always_comb begin
    cnt_nxt   = cnt + CNT_ONE;
    phase_nxt = phase;
    wrap      = (cnt == CNT_LAST);
    if (wrap) begin
      // Terminal count: restart the half period and flip the phase on this edge.
      cnt_nxt   = '0;
      phase_nxt = (phase == PH_ON) ? PH_OFF : PH_ON;
    end
  end

`ifdef BLINK_PWM_DIM_EN
  // ------------------------------------------------------------------
  // Dimming: gate the lit phase with a 256-step PWM.
  // ------------------------------------------------------------------
  // 9 bits so a duty of 256 (always lit) is representable.
  localparam logic [8:0] DUTY9 = 9'((DIM_DUTY > 256) ? 256 : ((DIM_DUTY < 0) ? 0 : DIM_DUTY));

  logic [7:0] pwm_cnt = '0;
  logic       pwm_on;

  always_comb begin
    pwm_on  = ({1'b0, pwm_cnt} < DUTY9);
    // Gate from the current phase; the register below adds the one extra edge.
    led_nxt = ((phase == PH_ON) && pwm_on) ^ LED_ACTIVE_LOW;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
    end
  end
`else
  // Plain square wave: the pin register loads the next phase directly so it
  // changes on the very edge the phase does.
  always_comb begin
    led_nxt = (phase_nxt == PH_ON) ^ LED_ACTIVE_LOW;
  end
`endif

  // ------------------------------------------------------------------
  // State registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      phase <= PH_OFF;
      led_q <= OFF_LVL;
    end else begin
      cnt   <= cnt_nxt;
      phase <= phase_nxt;
      led_q <= led_nxt;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_blink.sv
// Directed bench for blink: several parameterisations share one clock and reset.
// Edge numbering: edge 1 is the first rising edge with rst=0. For HALF=H the plain
// build has led lit after edge e when floor(e/H) is odd.

module tb_blink;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   gcnt = 0;
  int   checks = 0;
  int   failures = 0;

  logic led_h5, led_al, led_h1, led_big, led_nr;

  always #5 clk = ~clk;
  always @(posedge clk) gcnt <= gcnt + 1;

  // HALF = 100/(2*10) = 5
  blink #(.CLK_HZ(100), .BLINK_HZ(10), .LED_ACTIVE_LOW(1'b0), .DIM_DUTY(64))
    u_h5 (.clk(clk), .rst(rst), .led(led_h5));
  // HALF = 5, inverted pin
  blink #(.CLK_HZ(100), .BLINK_HZ(10), .LED_ACTIVE_LOW(1'b1), .DIM_DUTY(64))
    u_al (.clk(clk), .rst(rst), .led(led_al));
  // HALF = 1
  blink #(.CLK_HZ(2), .BLINK_HZ(1), .LED_ACTIVE_LOW(1'b0), .DIM_DUTY(64))
    u_h1 (.clk(clk), .rst(rst), .led(led_h1));
  // HALF = 1000 (non power of two, 10-bit counter)
  blink #(.CLK_HZ(2000), .BLINK_HZ(1), .LED_ACTIVE_LOW(1'b0), .DIM_DUTY(64))
    u_big (.clk(clk), .rst(rst), .led(led_big));
  // HALF = 5, reset never asserted
  blink #(.CLK_HZ(100), .BLINK_HZ(10), .LED_ACTIVE_LOW(1'b0), .DIM_DUTY(64))
    u_nr (.clk(clk), .rst(1'b0), .led(led_nr));

`ifdef BLINK_PWM_DIM_EN
  logic led_pw, led_pw0;
  // HALF = 2048/2 = 1024
  blink #(.CLK_HZ(2048), .BLINK_HZ(1), .LED_ACTIVE_LOW(1'b0), .DIM_DUTY(64))
    u_pw (.clk(clk), .rst(rst), .led(led_pw));
  blink #(.CLK_HZ(2048), .BLINK_HZ(1), .LED_ACTIVE_LOW(1'b0), .DIM_DUTY(0))
    u_pw0 (.clk(clk), .rst(rst), .led(led_pw0));
`endif

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instance with rst tied low from time 0: counts from the first edge ever.
  task automatic test_noreset();
    logic exp;
    #1;
    checks++;
    if (led_nr !== 1'b0) begin
      failures++;
      $display("FAIL noreset_powerup got=%b want=0", led_nr);
    end
    for (int i = 0; i < 14; i++) begin
      tick();
      exp = ((gcnt / 5) % 2) == 1;
      checks++;
      if (led_nr !== exp) begin
        failures++;
        $display("FAIL noreset edge=%0d got=%b want=%b", gcnt, led_nr, exp);
      end
    end
  endtask

  // Three edges of reset: every instance must sit at its off level.
  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({led_h5, led_al, led_h1, led_big} !== 4'b0100) begin
        failures++;
        $display("FAIL reset_level cyc=%0d got=%b want=0100", i,
                 {led_h5, led_al, led_h1, led_big});
      end
    end
  endtask

  // Release and compare every edge against the floor(e/H) parity rule.
  task automatic test_divider();
    logic e5, e1, eb;
    rst = 1'b0;
    for (int e = 1; e <= 2100; e++) begin
      tick();
      e5 = ((e / 5) % 2) == 1;
      e1 = (e % 2) == 1;
      eb = ((e / 1000) % 2) == 1;
      checks++;
      if (led_h5 !== e5) begin
        failures++;
        $display("FAIL half5 edge=%0d got=%b want=%b", e, led_h5, e5);
      end
      checks++;
      if (led_al !== ~e5) begin
        failures++;
        $display("FAIL active_low edge=%0d got=%b want=%b", e, led_al, ~e5);
      end
      checks++;
      if (led_h1 !== e1) begin
        failures++;
        $display("FAIL half1 edge=%0d got=%b want=%b", e, led_h1, e1);
      end
      checks++;
      if (led_big !== eb) begin
        failures++;
        $display("FAIL half1000 edge=%0d got=%b want=%b", e, led_big, eb);
      end
    end
  endtask

  // Reset pulse while lit: off next edge, then timing restarts from edge 1.
  task automatic test_midreset();
    logic e5;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int e = 1; e <= 7; e++) tick();
    checks++;
    if (led_h5 !== 1'b1) begin
      failures++;
      $display("FAIL midreset_lit_at7 got=%b want=1", led_h5);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({led_h5, led_al} !== 2'b01) begin
      failures++;
      $display("FAIL midreset_off got=%b want=01", {led_h5, led_al});
    end
    rst = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      e5 = ((e / 5) % 2) == 1;
      checks++;
      if ({led_h5, led_al} !== {e5, ~e5}) begin
        failures++;
        $display("FAIL midreset_restart edge=%0d got=%b want=%b", e,
                 {led_h5, led_al}, {e5, ~e5});
      end
    end
  endtask

`ifdef BLINK_PWM_DIM_EN
  // After edge e: phase before it = floor((e-1)/1024) odd, pwm before it = (e-1)%256.
  task automatic test_pwm_dim();
    logic exp;
    int   highs;
    highs = 0;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({led_pw, led_pw0} !== 2'b00) begin
      failures++;
      $display("FAIL pwm_reset got=%b want=00", {led_pw, led_pw0});
    end
    rst = 1'b0;
    for (int e = 1; e <= 2300; e++) begin
      tick();
      exp = ((((e - 1) / 1024) % 2) == 1) && (((e - 1) % 256) < 64);
      if (led_pw === 1'b1 && e >= 1025 && e <= 1280) highs++;
      checks++;
      if (led_pw !== exp) begin
        failures++;
        $display("FAIL pwm_dim edge=%0d got=%b want=%b", e, led_pw, exp);
      end
      checks++;
      if (led_pw0 !== 1'b0) begin
        failures++;
        $display("FAIL pwm_duty0 edge=%0d got=%b want=0", e, led_pw0);
      end
    end
    checks++;
    if (highs != 64) begin
      failures++;
      $display("FAIL pwm_highs_per_256 got=%0d want=64", highs);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    test_noreset();
`ifdef BLINK_PWM_DIM_EN
    test_pwm_dim();
`else
    test_reset();
    test_divider();
    test_midreset();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
